// File: rtl/qam_gray_codec_if.sv
// Symbol stream bundle for qam_gray_codec: input handshake with flush,
// output handshake and transfer counter. DW = NUM_CH * 2 * bits-per-axis.
interface qam_gray_codec_if #(
  parameter int DW        = 4,
  parameter int CNT_WIDTH = 16
);
  logic                 i_flush;
  logic                 i_mode;
  logic [DW-1:0]        i_data;
  logic                 i_dv;
  logic                 i_rdy;
  logic [DW-1:0]        o_data;
  logic                 o_mode;
  logic                 o_dv;
  logic                 o_rdy;
  logic [CNT_WIDTH-1:0] o_sym_cnt;

  modport master (
    output i_flush, i_mode, i_data, i_dv, o_rdy,
    input  i_rdy, o_data, o_mode, o_dv, o_sym_cnt
  );

  modport slave (
    input  i_flush, i_mode, i_data, i_dv, o_rdy,
    output i_rdy, o_data, o_mode, o_dv, o_sym_cnt
  );
endinterface

// File: rtl/qam_gray_codec.sv
// Per-axis Gray<->binary converter for square QAM; latency PIPE_STAGES cycles.
// Backpressure: elastic stall pipeline, o_rdy reaches i_rdy combinationally.
module qam_gray_codec #(
  parameter int MODULATION_ORDER = 16,
  parameter int NUM_CH           = 1,
  parameter int PIPE_STAGES      = 2,
  parameter int CNT_WIDTH        = 16
) (
  input logic              clk,
  input logic              rst,
  qam_gray_codec_if.slave  bus
);
  localparam int LOG2M = $clog2(MODULATION_ORDER);
  localparam int W     = LOG2M / 2;
  localparam int SYM   = 2 * W;
  localparam int DW    = NUM_CH * SYM;
  localparam int LAST  = PIPE_STAGES - 1;

  generate
    if (MODULATION_ORDER < 4 || (1 << LOG2M) != MODULATION_ORDER || (LOG2M % 2) != 0) begin : g_bad_order
      $error("qam_gray_codec: MODULATION_ORDER must be a power of 4 and >= 4");
    end
    if (NUM_CH < 1 || PIPE_STAGES < 1) begin : g_bad_shape
      $error("qam_gray_codec: NUM_CH and PIPE_STAGES must be >= 1");
    end
  endgenerate

  function automatic logic [W-1:0] gray_to_bin(input logic [W-1:0] g);
    logic [W-1:0] b;
    b[W-1] = g[W-1];
    for (int k = W - 2; k >= 0; k--) begin
      b[k] = b[k+1] ^ g[k];
    end
    return b;
  endfunction

  function automatic logic [W-1:0] bin_to_gray(input logic [W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  logic [DW-1:0]          conv_dat;
  logic [DW-1:0]          dat_q [PIPE_STAGES];
  logic [PIPE_STAGES-1:0] mode_q;
  logic [PIPE_STAGES-1:0] vld_q;
  logic [PIPE_STAGES-1:0] adv;
  logic [CNT_WIDTH-1:0]   cnt_q;
  logic                   rdy;
  logic                   in_xfer;
  logic                   out_xfer;

  // Every I and Q field of every channel is an independent W-bit axis index.
  always_comb begin
    conv_dat = '0;
    for (int f = 0; f < 2 * NUM_CH; f++) begin
      conv_dat[f*W +: W] = bus.i_mode ? bin_to_gray(bus.i_data[f*W +: W])
                                      : gray_to_bin(bus.i_data[f*W +: W]);
    end
  end

  // A stage may load when it is empty or the stage after it is moving.
  always_comb begin
    adv       = '0;
    adv[LAST] = !vld_q[LAST] || bus.o_rdy;
    for (int s = LAST - 1; s >= 0; s--) begin
      adv[s] = !vld_q[s] || adv[s+1];
    end
  end

  assign rdy      = adv[0] && !bus.i_flush;
  assign in_xfer  = bus.i_dv && rdy;
  assign out_xfer = vld_q[LAST] && bus.o_rdy;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q  <= '0;
      mode_q <= '0;
      cnt_q  <= '0;
      for (int s = 0; s < PIPE_STAGES; s++) begin
        dat_q[s] <= '0;
      end
    end else begin
      if (out_xfer) begin
        cnt_q <= cnt_q + CNT_WIDTH'(1);
      end
      if (adv[0]) begin
        dat_q[0]  <= conv_dat;
        mode_q[0] <= bus.i_mode;
        vld_q[0]  <= in_xfer;
      end
      for (int s = 1; s < PIPE_STAGES; s++) begin
        if (adv[s]) begin
          dat_q[s]  <= dat_q[s-1];
          mode_q[s] <= mode_q[s-1];
          vld_q[s]  <= vld_q[s-1];
        end
      end
      // Flush drops in-flight symbols but leaves data registers as they are.
      if (bus.i_flush) begin
        vld_q <= '0;
      end
    end
  end

  assign bus.i_rdy     = rdy;
  assign bus.o_dv      = vld_q[LAST];
  assign bus.o_data    = dat_q[LAST];
  assign bus.o_mode    = mode_q[LAST];
  assign bus.o_sym_cnt = cnt_q;
endmodule

// File: tb/tb_qam_gray_codec.sv
// Scoreboard bench: A = 64-QAM, 2 channels, 3 stages, 4-bit counter; B = 16-QAM, 1 channel, 2 stages.
module tb_qam_gray_codec;
  localparam int A_DW = 12;
  localparam int B_DW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  qam_gray_codec_if #(.DW(A_DW), .CNT_WIDTH(4))  a ();
  qam_gray_codec_if #(.DW(B_DW), .CNT_WIDTH(16)) b ();

  qam_gray_codec #(.MODULATION_ORDER(64), .NUM_CH(2), .PIPE_STAGES(3), .CNT_WIDTH(4))
    dut_a (.clk(clk), .rst(rst), .bus(a));
  qam_gray_codec #(.MODULATION_ORDER(16), .NUM_CH(1), .PIPE_STAGES(2), .CNT_WIDTH(16))
    dut_b (.clk(clk), .rst(rst), .bus(b));

  typedef struct {
    logic [31:0] d;
    logic        m;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea;
  exp_t eb;
  int   n_vec  = 0;
  int   n_err  = 0;
  int   a_pops = 0;
  int   b_pops = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: Gray code of v is v^(v>>1); its inverse is found by search.
  function automatic int gray(input int v);
    return v ^ (v >> 1);
  endfunction

  function automatic int inv_gray(input int g, input int w);
    for (int u = 0; u < (1 << w); u++) begin
      if (gray(u) == g) return u;
    end
    return -1;
  endfunction

  function automatic logic [31:0] ref_conv(input logic [31:0] d, input logic m, input int w, input int nch);
    logic [31:0] r;
    int          v;
    int          o;
    r = '0;
    for (int f = 0; f < 2 * nch; f++) begin
      v = int'(d >> (f * w)) & ((1 << w) - 1);
      o = m ? gray(v) : inv_gray(v, w);
      r = r | (32'(o) << (f * w));
    end
    return r;
  endfunction

  // Stimulus side: record the expected response of every accepted symbol.
  always @(negedge clk) begin
    if (!rst && a.i_dv && a.i_rdy) qa.push_back('{ref_conv(32'(a.i_data), a.i_mode, 3, 2), a.i_mode});
    if (!rst && b.i_dv && b.i_rdy) qb.push_back('{ref_conv(32'(b.i_data), b.i_mode, 2, 1), b.i_mode});
  end

  // Monitors: compare every output transfer against the oldest expectation.
  always @(negedge clk) begin
    if (!rst && a.o_dv && a.o_rdy) begin
      if (qa.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL a_unexpected: got 0x%0h, expected no output", a.o_data);
      end else begin
        ea = qa.pop_front();
        chk("a_data", 32'(a.o_data), ea.d);
        chk("a_mode", 32'(a.o_mode), 32'(ea.m));
        a_pops++;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && b.o_dv && b.o_rdy) begin
      if (qb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL b_unexpected: got 0x%0h, expected no output", b.o_data);
      end else begin
        eb = qb.pop_front();
        chk("b_data", 32'(b.o_data), eb.d);
        chk("b_mode", 32'(b.o_mode), 32'(eb.m));
        b_pops++;
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain_a();
    a.i_dv  = 1'b0;
    a.o_rdy = 1'b1;
    for (int k = 0; k < 100 && qa.size() != 0; k++) tick();
    chk("a_drain_left", 32'(qa.size()), 32'd0);
    @(negedge clk);
    chk("a_cnt", 32'(a.o_sym_cnt), 32'(a_pops % 16));
  endtask

  task automatic drain_b();
    b.i_dv  = 1'b0;
    b.o_rdy = 1'b1;
    for (int k = 0; k < 100 && qb.size() != 0; k++) tick();
    chk("b_drain_left", 32'(qb.size()), 32'd0);
    @(negedge clk);
    chk("b_cnt", 32'(b.o_sym_cnt), 32'(b_pops));
  endtask

  initial begin
    int          sent;
    int          acc;
    bit          have;
    logic [11:0] snap;
    logic        snapm;

    a.i_flush = 1'b0; a.i_mode = 1'b0; a.i_data = '0; a.i_dv = 1'b0; a.o_rdy = 1'b0;
    b.i_flush = 1'b0; b.i_mode = 1'b0; b.i_data = '0; b.i_dv = 1'b0; b.o_rdy = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_a_odv",  32'(a.o_dv),      32'd0);
    chk("rst_a_data", 32'(a.o_data),    32'd0);
    chk("rst_a_mode", 32'(a.o_mode),    32'd0);
    chk("rst_a_cnt",  32'(a.o_sym_cnt), 32'd0);
    chk("rst_a_irdy", 32'(a.i_rdy),     32'd1);
    chk("rst_b_irdy", 32'(b.i_rdy),     32'd1);

    // 16-QAM latency: I=11,Q=10 in Gray -> I=10,Q=11 two cycles later.
    b.i_dv = 1'b1; b.i_data = 4'b1110; b.i_mode = 1'b0; b.o_rdy = 1'b1;
    tick();
    b.i_dv = 1'b0;
    @(negedge clk);
    chk("b_lat_early", 32'(b.o_dv), 32'd0);
    tick();
    @(negedge clk);
    chk("b_lat_odv",  32'(b.o_dv),   32'd1);
    chk("b_lat_data", 32'(b.o_data), 32'hB);
    chk("b_lat_mode", 32'(b.o_mode), 32'd0);
    tick();

    // Every 16-QAM code in both directions, back to back.
    for (int v = 0; v < 32; v++) begin
      b.i_data = 4'(v);
      b.i_mode = v[4];
      b.i_dv   = 1'b1;
      tick();
    end
    drain_b();

    // 64-QAM, alternating modes: ch0 I=101 (to Gray) -> 111, then I=111 (to binary) -> 101.
    a.o_rdy = 1'b1;
    a.i_dv = 1'b1; a.i_mode = 1'b1; a.i_data = {6'($urandom), 3'b101, 3'b000};
    tick();
    a.i_mode = 1'b0; a.i_data = {6'($urandom), 3'b111, 3'b000};
    tick();
    a.i_dv = 1'b0;
    tick();
    @(negedge clk);
    chk("alt0_i",    32'(a.o_data[5:3]), 32'b111);
    chk("alt0_mode", 32'(a.o_mode),      32'd1);
    tick();
    @(negedge clk);
    chk("alt1_i",    32'(a.o_data[5:3]), 32'b101);
    chk("alt1_mode", 32'(a.o_mode),      32'd0);
    drain_a();

    // Random stream of 1000 symbols with random modes and 50% downstream ready.
    sent = 0;
    for (int cyc = 0; cyc < 20000 && sent < 1000; cyc++) begin
      a.i_dv   = ($urandom % 4) != 0;
      a.i_data = 12'($urandom);
      a.i_mode = 1'($urandom);
      a.o_rdy  = 1'($urandom);
      @(negedge clk);
      if (a.i_dv && a.i_rdy) sent++;
      tick();
    end
    chk("stream_sent", 32'(sent), 32'd1000);
    drain_a();

    // Stall: 10 cycles of o_rdy low with input offered every cycle.
    tick();
    a.o_rdy = 1'b0;
    acc = 0;
    have = 1'b0;
    snap = '0;
    snapm = 1'b0;
    for (int k = 0; k < 10; k++) begin
      a.i_dv   = 1'b1;
      a.i_data = 12'($urandom);
      a.i_mode = 1'($urandom);
      @(negedge clk);
      if (a.i_dv && a.i_rdy) acc++;
      if (a.o_dv) begin
        if (!have) begin
          snap  = a.o_data;
          snapm = a.o_mode;
          have  = 1'b1;
        end else begin
          chk("stall_data_stable", 32'(a.o_data), 32'(snap));
          chk("stall_mode_stable", 32'(a.o_mode), 32'(snapm));
        end
      end
      tick();
    end
    chk("stall_accepted", 32'(acc), 32'd3);
    @(negedge clk);
    chk("stall_irdy", 32'(a.i_rdy), 32'd0);
    chk("stall_odv",  32'(a.o_dv),  32'd1);
    tick();
    a.o_rdy = 1'b1;
    @(negedge clk);
    chk("unstall_irdy", 32'(a.i_rdy), 32'd1);
    drain_a();

    // Flush with symbols in flight, one leaving in the flush cycle, and i_dv high.
    tick();
    a.o_rdy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      a.i_dv = 1'b1; a.i_data = 12'($urandom); a.i_mode = 1'($urandom);
      tick();
    end
    a.i_flush = 1'b1;
    a.i_data  = 12'($urandom);
    @(negedge clk);
    chk("flush_irdy", 32'(a.i_rdy), 32'd0);
    tick();
    a.i_flush = 1'b0;
    a.i_dv    = 1'b0;
    qa.delete();
    @(negedge clk);
    chk("flush_odv", 32'(a.o_dv), 32'd0);
    tick();
    a.i_dv = 1'b1; a.i_data = 12'($urandom); a.i_mode = 1'($urandom);
    tick();
    chk("post_flush_queued", 32'(qa.size()), 32'd1);
    drain_a();

    // Reset mid-stream: everything clears and nothing stale emerges later.
    tick();
    a.o_rdy = 1'b1;
    for (int k = 0; k < 2; k++) begin
      a.i_dv = 1'b1; a.i_data = 12'($urandom); a.i_mode = 1'b1;
      tick();
    end
    rst = 1'b1;
    tick();
    qa.delete();
    qb.delete();
    a_pops = 0;
    b_pops = 0;
    @(negedge clk);
    chk("mid_rst_odv",  32'(a.o_dv),      32'd0);
    chk("mid_rst_data", 32'(a.o_data),    32'd0);
    chk("mid_rst_mode", 32'(a.o_mode),    32'd0);
    chk("mid_rst_cnt",  32'(a.o_sym_cnt), 32'd0);
    tick();
    rst = 1'b0;
    a.i_dv = 1'b0;
    @(negedge clk);
    chk("post_rst_irdy", 32'(a.i_rdy), 32'd1);
    for (int k = 0; k < 5; k++) begin
      tick();
      @(negedge clk);
      chk("post_rst_quiet", 32'(a.o_dv), 32'd0);
    end

    // 17 transfers through a 4-bit counter wrap it to 1.
    tick();
    for (int k = 0; k < 17; k++) begin
      a.i_dv = 1'b1; a.i_data = 12'($urandom); a.i_mode = 1'($urandom);
      tick();
    end
    drain_a();
    chk("cnt_wrap", 32'(a.o_sym_cnt), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/qam_gray_codec.md
# qam_gray_codec

Parametrised, multi-channel, pipelined Gray/binary converter for square QAM constellations, with per-symbol mode selection and a valid/ready handshake. Each channel carries one I and one Q axis index. Every symbol is converted Gray→binary (demapper side) or binary→Gray (mapper side). It sits between the constellation slicer/mapper and the bit (de)interleaver, and it adds backpressure, flush and a transfer counter.

## Interface

Parameters:
- MODULATION_ORDER, 16, constellation size M. Must be a power of 4 and ≥ 4; any other value is an elaboration error.
- NUM_CH, 1, number of parallel channels (≥ 1).
- PIPE_STAGES, 2, number of register stages (≥ 1).
- CNT_WIDTH, 16, width of the transfer counter.
- Derived: W = $clog2(MODULATION_ORDER)/2 bits per axis; SYM = 2*W bits per channel.

Ports:
- clk  in  1  clock; the block has one clock domain.
- rst  in  1  reset, synchronous, active-high.
- i_flush  in  1  synchronous pipeline clear; the counter is retained.
- i_mode  in  1  0 = Gray→binary, 1 = binary→Gray; sampled with each accepted symbol.
- i_data  in  NUM_CH*SYM  channel c occupies bits [c*SYM +: SYM]; I is the upper W bits, Q the lower W bits.
- i_dv  in  1  input valid.
- i_rdy  out  1  input ready.
- o_data  out  NUM_CH*SYM  converted data, same packing as i_data.
- o_mode  out  1  mode the output symbol was converted with.
- o_dv  out  1  output valid.
- o_rdy  in  1  downstream ready.
- o_sym_cnt  out  CNT_WIDTH  count of completed output transfers.

## Operation

- Transfers: an input transfer occurs when i_dv && i_rdy; an output transfer occurs when o_dv && o_rdy.
- Conversion is done independently per axis and per channel:
  - Gray→binary: b[W-1] = g[W-1]; b[k] = b[k+1] ^ g[k] for k = W-2 down to 0.
  - Binary→Gray: g = b ^ (b >> 1).
- The conversion is combinational and placed before stage 0. Stages 1..PIPE_STAGES-1 are pure delay.
- Mode travels with the symbol, so symbols of mixed modes may be back-to-back and each is converted correctly. o_mode reports the mode of the symbol currently on o_data.
- Pipeline is elastic. Each stage holds a valid bit plus data and mode.
  - adv[last] = !valid[last] || o_rdy.
  - adv[s] = !valid[s] || adv[s+1].
  - i_rdy = adv[0] && !i_flush.
  - The path from o_rdy to i_rdy is combinational; this is the intended design.
- When a stage advances, it loads the previous stage (or the input, for stage 0); its valid becomes the upstream valid/transfer.
- When a stage holds, its data, mode and valid are frozen.
- o_dv = valid[last], and o_data/o_mode come directly from the last stage registers. Stable-while-stalled: with o_dv high and o_rdy low, o_data and o_mode do not change.
- o_sym_cnt increments by 1 on each output transfer and wraps from 2^CNT_WIDTH-1 to 0.
- Flush: all valids clear on the next edge and in-flight symbols are discarded. i_rdy is 0 while i_flush is high, so no input is accepted that cycle (flush wins over a simultaneous i_dv). An output transfer in the same cycle as a flush is still counted. Data registers are not cleared by flush.
- rst: all valids, data, mode and o_sym_cnt are cleared to 0. rst overrides flush and any transfer. Reset mid-stream discards all in-flight symbols.

## Timing

- Reset values: o_dv = 0, o_data = 0, o_mode = 0, o_sym_cnt = 0. i_rdy = 1 in the first cycle after rst deasserts, provided i_flush = 0.
- Latency: a symbol accepted at edge N appears with o_dv = 1 after edge N+PIPE_STAGES-1, i.e. PIPE_STAGES cycles from accept to presentation, when there are no stalls.
- Throughput: 1 symbol per cycle with o_rdy held high. No bubbles are inserted.
- With o_rdy held low, the pipeline fills to PIPE_STAGES symbols, then i_rdy goes low. When o_rdy rises, i_rdy rises in the same cycle.
- No symbol is dropped or duplicated under any o_rdy pattern.

## Test plan

- M=16, NUM_CH=1, mode 0: I=2'b11, Q=2'b10 → I=2'b10, Q=2'b11 after 2 cycles with o_mode = 0. Sweep all 16 codes and check against the formula.
- M=64, NUM_CH=2, alternating mode each cycle: ch0 I=3'b101 in mode 1 → 3'b111; the next symbol, 3'b111 in mode 0 → 3'b101. Verify per-symbol o_mode and channel packing.
- Random o_rdy (50%) with a 1000-symbol stream, PIPE_STAGES = 3: the output sequence equals the model exactly. Hold o_rdy low for 10 cycles: exactly 3 symbols buffered, i_rdy = 0, and o_data stable throughout.
- Flush with 2 symbols in flight and i_dv = 1: o_dv = 0 on the next cycle, the flushed-cycle input is not accepted, and the following symbol passes normally.
- CNT_WIDTH = 4: 17 output transfers → o_sym_cnt reads 1 (wrapped). Assert rst mid-stream: all outputs 0 the next cycle and no stale symbol emerges afterwards.
